mem_port_arbiter: RTL and testbench

//  Shares one single-port memory_ip instance between two requesters: the Processor
//  (P side) and the external loader/debug host (E side). Replaces the ad-hoc priority

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 25 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and default widths for the memory port arbiter
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_RD_LAT = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic OWN_P = 1'b0;
  localparam logic OWN_E = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way pick between processor and external requests
module rr_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int EXT_PRIO = 0
) (
  input  logic req_p,
  input  logic req_e,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req_p | req_e;
    winner = OWN_P;
    if (req_p && req_e) begin
      // On a tie the side that did not own the last transaction goes next.
      winner = (EXT_PRIO != 0) ? OWN_E : ~last_owner;
    end else if (req_e) begin
      winner = OWN_E;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises processor and external-host accesses onto one single-port memory
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_LAT   = DEF_RD_LAT,
  parameter int EXT_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              e_req,
  input  logic              e_we,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_gnt,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,
  input  logic              ext_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              owner
);

  localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

  logic [1:0] state;
  logic [1:0] wait_cnt;
  logic       last_owner;
  logic       cur_we;
  logic       arb_valid;
  logic       arb_winner;
  logic       p_eligible;

  assign p_eligible = p_req & ~ext_lock;
  assign busy       = (state != ST_IDLE);

  rr_arbiter2 #(
    .EXT_PRIO(EXT_PRIO)
  ) u_arb (
    .req_p     (p_eligible),
    .req_e     (e_req),
    .last_owner(last_owner),
    .valid     (arb_valid),
    .winner    (arb_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= 2'd0;
      last_owner <= OWN_E;
      cur_we     <= 1'b0;
      owner      <= OWN_P;
      p_gnt      <= 1'b0;
      e_gnt      <= 1'b0;
      p_rvalid   <= 1'b0;
      e_rvalid   <= 1'b0;
      p_rdata    <= '0;
      e_rdata    <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_rden   <= 1'b0;
      mem_wren   <= 1'b0;
    end else begin
      p_gnt    <= 1'b0;
      e_gnt    <= 1'b0;
      p_rvalid <= 1'b0;
      e_rvalid <= 1'b0;
      mem_rden <= 1'b0;
      mem_wren <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            state      <= ST_ISSUE;
            owner      <= arb_winner;
            last_owner <= arb_winner;
            if (arb_winner == OWN_E) begin
              e_gnt    <= 1'b1;
              mem_addr <= e_addr;
              mem_data <= e_wdata;
              cur_we   <= e_we;
              mem_wren <= e_we;
              mem_rden <= ~e_we;
            end else begin
              p_gnt    <= 1'b1;
              mem_addr <= p_addr;
              mem_data <= p_wdata;
              cur_we   <= p_we;
              mem_wren <= p_we;
              mem_rden <= ~p_we;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt <= WAIT_LOAD;
          state    <= cur_we ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          // mem_q is valid only during the final wait cycle; capture it on that edge.
          if (wait_cnt == 2'd0) begin
            state <= ST_RESP;
            if (owner == OWN_E) begin
              e_rdata  <= mem_q;
              e_rvalid <= 1'b1;
            end else begin
              p_rdata  <= mem_q;
              p_rvalid <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst[2], ext_lock[2], mem_clr;
  logic          p_req[2], p_we[2], e_req[2], e_we[2];
  logic [AW-1:0] p_addr[2], e_addr[2];
  logic [DW-1:0] p_wdata[2], e_wdata[2];
  logic          p_gnt[2], p_rvalid[2], e_gnt[2], e_rvalid[2];
  logic [DW-1:0] p_rdata[2], e_rdata[2];
  logic [AW-1:0] mem_addr[2];
  logic [DW-1:0] mem_data[2], mem_q[2];
  logic          mem_rden[2], mem_wren[2], busy[2], owner[2];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .EXT_PRIO(0)) u0 (
    .clk(clk), .rst(rst[0]),
    .p_req(p_req[0]), .p_we(p_we[0]), .p_addr(p_addr[0]), .p_wdata(p_wdata[0]),
    .p_gnt(p_gnt[0]), .p_rvalid(p_rvalid[0]), .p_rdata(p_rdata[0]),
    .e_req(e_req[0]), .e_we(e_we[0]), .e_addr(e_addr[0]), .e_wdata(e_wdata[0]),
    .e_gnt(e_gnt[0]), .e_rvalid(e_rvalid[0]), .e_rdata(e_rdata[0]),
    .ext_lock(ext_lock[0]), .mem_addr(mem_addr[0]), .mem_data(mem_data[0]),
    .mem_rden(mem_rden[0]), .mem_wren(mem_wren[0]), .mem_q(mem_q[0]),
    .busy(busy[0]), .owner(owner[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .EXT_PRIO(1)) u1 (
    .clk(clk), .rst(rst[1]),
    .p_req(p_req[1]), .p_we(p_we[1]), .p_addr(p_addr[1]), .p_wdata(p_wdata[1]),
    .p_gnt(p_gnt[1]), .p_rvalid(p_rvalid[1]), .p_rdata(p_rdata[1]),
    .e_req(e_req[1]), .e_we(e_we[1]), .e_addr(e_addr[1]), .e_wdata(e_wdata[1]),
    .e_gnt(e_gnt[1]), .e_rvalid(e_rvalid[1]), .e_rdata(e_rdata[1]),
    .ext_lock(ext_lock[1]), .mem_addr(mem_addr[1]), .mem_data(mem_data[1]),
    .mem_rden(mem_rden[1]), .mem_wren(mem_wren[1]), .mem_q(mem_q[1]),
    .busy(busy[1]), .owner(owner[1])
  );

  // Memory stand-in: q carries read data only RD_LAT edges after rden, garbage otherwise.
  logic [DW-1:0] mem[2][512];
  logic [DW-1:0] rd_pipe[2][3];
  assign mem_q[0] = rd_pipe[0][0];
  assign mem_q[1] = rd_pipe[1][2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_clr) begin
        for (int a = 0; a < 512; a++) mem[i][a] <= '0;
      end else if (mem_wren[i]) begin
        mem[i][mem_addr[i]] <= mem_data[i];
      end
      rd_pipe[i][0] <= mem_rden[i] ? mem[i][mem_addr[i]] : 16'hDEAD;
      rd_pipe[i][1] <= rd_pipe[i][0];
      rd_pipe[i][2] <= rd_pipe[i][1];
    end
  end

  // Transaction model: one in-flight access, m_t = cycles since its sampling edge.
  bit            m_act[2], m_side[2], m_we[2], m_last[2], m_owner[2];
  int            m_t[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_data[2], m_prd[2], m_erd[2];
  logic [DW-1:0] ref_mem[2][512];

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit prio(int i);
    return (i == 1);
  endfunction

  task automatic model_step(int i);
    bit rp, re, win;
    if (mem_clr) for (int a = 0; a < 512; a++) ref_mem[i][a] = '0;
    if (rst[i]) begin
      m_act[i] = 0; m_last[i] = 1; m_owner[i] = 0;
      m_addr[i] = '0; m_data[i] = '0; m_prd[i] = '0; m_erd[i] = '0;
    end else if (m_act[i]) begin
      m_t[i]++;
      if (!m_we[i] && m_t[i] == 2 + lat(i)) begin
        if (m_side[i]) m_erd[i] = ref_mem[i][m_addr[i]];
        else m_prd[i] = ref_mem[i][m_addr[i]];
      end
      if (m_t[i] > (m_we[i] ? 1 : 2 + lat(i))) m_act[i] = 0;
    end else begin
      rp = p_req[i] && !ext_lock[i];
      re = e_req[i];
      if (rp || re) begin
        win = (rp && re) ? (prio(i) ? 1'b1 : !m_last[i]) : re;
        m_act[i] = 1; m_t[i] = 1; m_side[i] = win;
        m_we[i] = win ? e_we[i] : p_we[i];
        m_addr[i] = win ? e_addr[i] : p_addr[i];
        m_data[i] = win ? e_wdata[i] : p_wdata[i];
        m_last[i] = win; m_owner[i] = win;
        if (m_we[i]) ref_mem[i][m_addr[i]] = m_data[i];
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0);
    model_step(1);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  function automatic void chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, i, cyc, act, exp);
    end
  endfunction

  bit x_iss, x_resp;
  initial forever begin
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      x_iss  = m_act[i] && m_t[i] == 1;
      x_resp = m_act[i] && !m_we[i] && m_t[i] == 2 + lat(i);
      chk("p_gnt", i, 32'(p_gnt[i]), 32'(x_iss && !m_side[i]));
      chk("e_gnt", i, 32'(e_gnt[i]), 32'(x_iss && m_side[i]));
      chk("mem_rden", i, 32'(mem_rden[i]), 32'(x_iss && !m_we[i]));
      chk("mem_wren", i, 32'(mem_wren[i]), 32'(x_iss && m_we[i]));
      chk("p_rvalid", i, 32'(p_rvalid[i]), 32'(x_resp && !m_side[i]));
      chk("e_rvalid", i, 32'(e_rvalid[i]), 32'(x_resp && m_side[i]));
      chk("p_rdata", i, 32'(p_rdata[i]), 32'(m_prd[i]));
      chk("e_rdata", i, 32'(e_rdata[i]), 32'(m_erd[i]));
      chk("mem_addr", i, 32'(mem_addr[i]), 32'(m_addr[i]));
      chk("mem_data", i, 32'(mem_data[i]), 32'(m_data[i]));
      chk("busy", i, 32'(busy[i]), 32'(m_act[i]));
      chk("owner", i, 32'(owner[i]), 32'(m_owner[i]));
      chk("rw_exclusive", i, 32'(mem_rden[i] && mem_wren[i]), 0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  int p_wait[2], e_gap[2], p_wait_max[2];

  task automatic rand_cycle(int i);
    if (rst[i]) rst[i] = 1'b0;
    else if ($urandom_range(0, 255) == 0) rst[i] = 1'b1;
    if ($urandom_range(0, 63) == 0) ext_lock[i] = ~ext_lock[i];
    if (p_req[i] && p_gnt[i]) begin
      p_req[i] = 1'b0;
      p_wait[i] = 0;
    end else if (p_req[i] && !ext_lock[i]) begin
      p_wait[i]++;
      if (p_wait[i] > p_wait_max[i]) p_wait_max[i] = p_wait[i];
    end
    if (!p_req[i] && $urandom_range(0, 2) == 0) begin
      p_req[i] = 1'b1; p_we[i] = 1'($urandom_range(0, 1));
      p_addr[i] = AW'($urandom_range(0, 15)); p_wdata[i] = DW'($urandom);
    end
    if (e_req[i] && e_gnt[i]) begin
      e_req[i] = 1'b0;
      e_gap[i] = $urandom_range(0, (i == 0) ? 1 : 6);
    end else if (!e_req[i]) begin
      if (e_gap[i] > 0) e_gap[i]--;
      else if ($urandom_range(0, 1) == 0) begin
        e_req[i] = 1'b1; e_we[i] = 1'($urandom_range(0, 1));
        e_addr[i] = AW'($urandom_range(0, 15)); e_wdata[i] = DW'($urandom);
      end
    end
  endtask

  initial begin
    mem_clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; ext_lock[i] = 1'b0;
      p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
      e_req[i] = 1'b0; e_we[i] = 1'b0; e_addr[i] = '0; e_wdata[i] = '0;
      p_wait[i] = 0; e_gap[i] = 0; p_wait_max[i] = 0;
    end
    tick(); tick();
    chk("reset_busy", 0, 32'(busy[0]), 0);
    chk("reset_owner", 0, 32'(owner[0]), 0);
    chk("reset_addr", 1, 32'(mem_addr[1]), 0);
    rst[0] = 1'b0; rst[1] = 1'b0; mem_clr = 1'b0;

    // Single read: E preloads 0xBEEF at 0x005, then P reads it back.
    e_req[0] = 1; e_we[0] = 1; e_addr[0] = 9'h005; e_wdata[0] = 16'hBEEF;
    tick(); chk("t1_e_gnt", 0, 32'(e_gnt[0]), 1); e_req[0] = 0;
    tick();
    p_req[0] = 1; p_we[0] = 0; p_addr[0] = 9'h005; p_wdata[0] = '0;
    tick(); chk("t1_p_gnt", 0, 32'(p_gnt[0]), 1); chk("t1_rden", 0, 32'(mem_rden[0]), 1);
    chk("t1_addr", 0, 32'(mem_addr[0]), 32'h005); p_req[0] = 0;
    tick(); chk("t1_rden_off", 0, 32'(mem_rden[0]), 0); chk("t1_early", 0, 32'(p_rvalid[0]), 0);
    tick(); chk("t1_rvalid", 0, 32'(p_rvalid[0]), 1); chk("t1_rdata", 0, 32'(p_rdata[0]), 32'hBEEF);
    tick(); chk("t1_idle", 0, 32'(busy[0]), 0);

    // Simultaneous writes after reset: P, E, P, E alternation.
    rst[0] = 1; tick(); rst[0] = 0;
    p_req[0] = 1; p_we[0] = 1; p_addr[0] = 9'h020; p_wdata[0] = 16'h1111;
    e_req[0] = 1; e_we[0] = 1; e_addr[0] = 9'h021; e_wdata[0] = 16'h2222;
    tick(); chk("t2_p_first", 0, 32'(p_gnt[0]), 1); chk("t2_e_wait", 0, 32'(e_gnt[0]), 0);
    chk("t2_wren", 0, 32'(mem_wren[0]), 1); p_addr[0] = 9'h022; p_wdata[0] = 16'h3333;
    tick(); chk("t2_gap", 0, 32'(mem_wren[0]), 0);
    tick(); chk("t2_e_second", 0, 32'(e_gnt[0]), 1); chk("t2_addr_e", 0, 32'(mem_addr[0]), 32'h021);
    e_addr[0] = 9'h023; e_wdata[0] = 16'h4444;
    tick();
    tick(); chk("t2_p_third", 0, 32'(p_gnt[0]), 1); chk("t2_data_p", 0, 32'(mem_data[0]), 32'h3333);
    p_req[0] = 0;
    tick();
    tick(); chk("t2_e_fourth", 0, 32'(e_gnt[0]), 1); e_req[0] = 0;
    tick();

    // ext_lock keeps P out while E writes then reads back 0x1234.
    ext_lock[0] = 1; p_req[0] = 1; p_we[0] = 0; p_addr[0] = 9'h030;
    e_req[0] = 1; e_we[0] = 1; e_addr[0] = 9'h010; e_wdata[0] = 16'h1234;
    tick(); chk("t3_e_wr", 0, 32'(e_gnt[0]), 1); chk("t3_p_locked", 0, 32'(p_gnt[0]), 0); e_req[0] = 0;
    tick(); e_req[0] = 1; e_we[0] = 0;
    tick(); chk("t3_e_rd", 0, 32'(e_gnt[0]), 1); chk("t3_p_locked2", 0, 32'(p_gnt[0]), 0); e_req[0] = 0;
    tick();
    tick(); chk("t3_rvalid", 0, 32'(e_rvalid[0]), 1); chk("t3_rdata", 0, 32'(e_rdata[0]), 32'h1234);
    ext_lock[0] = 0;
    tick(); chk("t3_p_not_yet", 0, 32'(p_gnt[0]), 0);
    tick(); chk("t3_p_unlocked", 0, 32'(p_gnt[0]), 1); p_req[0] = 0;
    tick(); tick(); tick();

    // Reset in the WAIT of an E read aborts it without a response.
    e_req[0] = 1; e_we[0] = 0; e_addr[0] = 9'h010;
    tick(); chk("t4_gnt", 0, 32'(e_gnt[0]), 1); e_req[0] = 0;
    tick(); rst[0] = 1;
    tick(); rst[0] = 0;
    chk("t4_busy", 0, 32'(busy[0]), 0); chk("t4_rden", 0, 32'(mem_rden[0]), 0);
    chk("t4_addr", 0, 32'(mem_addr[0]), 0); chk("t4_rdata", 0, 32'(e_rdata[0]), 0);
    for (int k = 0; k < 3; k++) begin
      tick(); chk("t4_no_rvalid", 0, 32'(e_rvalid[0]), 0);
    end

    // RD_LAT=3: P read then queued E read.
    e_req[1] = 1; e_we[1] = 1; e_addr[1] = 9'h007; e_wdata[1] = 16'hCAFE;
    tick(); chk("t5_e_wr", 1, 32'(e_gnt[1]), 1); e_req[1] = 0;
    tick();
    p_req[1] = 1; p_we[1] = 0; p_addr[1] = 9'h007;
    tick(); chk("t5_p_gnt", 1, 32'(p_gnt[1]), 1); chk("t5_rden", 1, 32'(mem_rden[1]), 1);
    p_req[1] = 0; e_req[1] = 1; e_we[1] = 0; e_addr[1] = 9'h008;
    for (int c = 2; c <= 6; c++) begin
      tick(); chk("t5_no_rden", 1, 32'(mem_rden[1]), 0);
      chk("t5_p_rvalid", 1, 32'(p_rvalid[1]), (c == 5) ? 1 : 0);
      if (c == 5) chk("t5_p_rdata", 1, 32'(p_rdata[1]), 32'hCAFE);
    end
    tick(); chk("t5_e_gnt_c7", 1, 32'(e_gnt[1]), 1); e_req[1] = 0;
    repeat (4) tick();
    chk("t5_e_rvalid", 1, 32'(e_rvalid[1]), 1); chk("t5_e_rdata", 1, 32'(e_rdata[1]), 0);
    tick();

    // EXT_PRIO=1: E wins four consecutive ties, then P goes.
    p_req[1] = 1; p_we[1] = 1; p_addr[1] = 9'h040; p_wdata[1] = 16'h0BAD;
    e_req[1] = 1; e_we[1] = 1; e_addr[1] = 9'h050; e_wdata[1] = 16'h5555;
    for (int k = 0; k < 4; k++) begin
      tick(); chk("t6_e_wins", 1, 32'(e_gnt[1]), 1); chk("t6_p_held", 1, 32'(p_gnt[1]), 0);
      chk("t6_addr", 1, 32'(mem_addr[1]), 32'(9'h050 + k));
      if (k == 3) e_req[1] = 0;
      else e_addr[1] = 9'(9'h051 + k);
      tick(); chk("t6_p_idle", 1, 32'(p_gnt[1]), 0);
    end
    tick(); chk("t6_p_last", 1, 32'(p_gnt[1]), 1); p_req[1] = 0;
    tick();

    repeat (4000) begin
      tick();
      rand_cycle(0);
      rand_cycle(1);
    end
    for (int i = 0; i < 2; i++) begin
      p_req[i] = 0; e_req[i] = 0; ext_lock[i] = 0; rst[i] = 0;
    end
    repeat (10) tick();
    for (int i = 0; i < 2; i++) begin
      chk("p_wait_bound", i, 32'(p_wait_max[i] <= 300), 1);
      chk("drained", i, 32'(busy[i]), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
